// File: rtl/byte_ram_ctrl_if.sv
// Request/response bus for byte_ram_ctrl: valid/ready request channel plus held response.
// The master drives requests and rsp_ready; the slave (the RAM controller) drives the rest.
interface byte_ram_ctrl_if #(
    parameter int unsigned ADDR_W = 25
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/byte_ram_ctrl.sv
// Byte-addressed data RAM with byte/half/word access; word-crossing accesses take two beats.
// Define RAM_BOUNDS_CHECK_EN to reject out-of-range accesses instead of wrapping modulo size.
module byte_ram_ctrl #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 25,
    parameter string       INIT_FILE   = ""
) (
    input logic            clk,
    input logic            rst,
    byte_ram_ctrl_if.slave bus
);
    localparam int unsigned ByteAw = $clog2(DEPTH_BYTES);
    localparam int unsigned WordAw = ByteAw - 2;
    localparam int unsigned Words  = DEPTH_BYTES / 4;

    typedef enum logic [1:0] {StIdle, StAcc, StAcc2, StResp} state_e;

    state_e            state_q, state_d;
    logic [WordAw-1:0] word_q, word_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              sgn_q, sgn_d;
    logic              cross_q, cross_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       rdata_q, rdata_d;

    // Word-wide array written with per-byte enables: four little-endian byte banks.
    logic [31:0] mem [Words];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic       accept;
    logic       req_cross;
    logic       req_oob;
    logic       req_err;
    logic [1:0] req_last;

    always_comb begin
        req_last  = 2'd0;
        req_cross = 1'b0;
        case (bus.req_size)
            2'b01: begin
                req_last  = 2'd1;
                req_cross = &bus.req_addr[1:0];
            end
            2'b10: begin
                req_last  = 2'd3;
                req_cross = |bus.req_addr[1:0];
            end
            default: ;
        endcase
    end

`ifdef RAM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH_BYTES);
    assign req_oob = ({1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, req_last}) >= DepthW;
`else
    // Modulo wrap: upper address bits and the access span play no part.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[ADDR_W-1:ByteAw], req_last};
    assign req_oob     = 1'b0;
`endif

    assign req_err       = (bus.req_size == 2'b11) || req_oob;
    assign bus.req_ready = !rst && (state_q == StIdle || (state_q == StResp && bus.rsp_ready));
    assign accept        = bus.req_valid && bus.req_ready;

    // ------------------------------------------------------------------
    // Datapath: beat address, store lanes, load alignment and extension
    // ------------------------------------------------------------------
    logic [WordAw-1:0] acc_idx;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [3:0]        size_mask;
    logic [7:0]        be_wide;
    logic [63:0]       wd_wide;
    logic [3:0]        mem_be;
    logic [63:0]       rd_pair;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;

    assign acc_idx = (state_q == StAcc2) ? word_q + WordAw'(1) : word_q;
    assign rd_word = mem[acc_idx];

    always_comb begin
        case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be_wide = 8'({4'b0000, size_mask} << off_q);
        wd_wide = {32'h0, wdata_q} << {off_q, 3'b000};

        mem_be  = 4'h0;
        wr_word = wd_wide[31:0];
        if (we_q && state_q == StAcc) begin
            mem_be = be_wide[3:0];
        end else if (we_q && state_q == StAcc2) begin
            mem_be  = be_wide[7:4];
            wr_word = wd_wide[63:32];
        end

        // Second beat pairs the next word above the low word captured in the first beat.
        rd_pair  = (state_q == StAcc2) ? {rd_word, lo_q} : {32'h0, rd_word};
        rd_shift = 32'(rd_pair >> {off_q, 3'b000});
        case (size_q)
            2'b00:   rd_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[acc_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        cross_d = cross_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: ;
            StAcc: begin
                if (cross_q) begin
                    lo_d    = rd_word;
                    state_d = StAcc2;
                end else begin
                    rdata_d = we_q ? 32'h0 : rd_ext;
                    state_d = StResp;
                end
            end
            StAcc2: begin
                rdata_d = we_q ? 32'h0 : rd_ext;
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accept in IDLE or on the response handshake edge; errors skip the access beats.
        if (accept) begin
            word_d  = bus.req_addr[ByteAw-1:2];
            off_d   = bus.req_addr[1:0];
            size_d  = bus.req_size;
            we_d    = bus.req_we;
            sgn_d   = bus.req_signed;
            wdata_d = bus.req_wdata;
            cross_d = req_cross;
            err_d   = req_err;
            rdata_d = 32'h0;
            state_d = req_err ? StResp : StAcc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            cross_q <= cross_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Self-checking bench for byte_ram_ctrl: byte-array reference model and response scoreboard.
module tb_byte_ram_ctrl;
    localparam int unsigned Depth = 1024;
    localparam int unsigned AddrW = 25;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [7:0] mem_m [Depth];

    always #5 clk = ~clk;

    byte_ram_ctrl_if #(.ADDR_W(AddrW)) bus ();

    byte_ram_ctrl #(
        .DEPTH_BYTES(Depth),
        .ADDR_W     (AddrW),
        .INIT_FILE  ("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input int unsigned addr, input logic [1:0] size,
                                               input logic sgn);
        logic [31:0] v = '0;
        for (int i = 0; i < int'(nbytes(size)); i++) v[8*i +: 8] = mem_m[10'((addr + i) % Depth)];
        if (sgn && size == 2'b00 && v[7]) v[31:8] = '1;
        if (sgn && size == 2'b01 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic model_store(input int unsigned addr, input logic [1:0] size,
                               input logic [31:0] wd);
        for (int i = 0; i < int'(nbytes(size)); i++) mem_m[10'((addr + i) % Depth)] = wd[8*i +: 8];
    endtask

    task automatic sb_push(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    // Called just after a falling edge; returns 1 time unit after the accepting rising edge.
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input int unsigned addr, input logic [31:0] wd);
        bit done = 1'b0;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = AddrW'(addr);
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.req_ready) done = 1'b1;
            else @(negedge clk);
        end
        check_eq("accept", 32'(done), 32'd1);
        if (done) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag);
        exp_t e;
        int   lat = 0;
        e = sb_q.pop_front();
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_eq({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        check_eq({tag, "_lat"}, 32'(lat), 32'(e.lat));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input int unsigned addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        sb_push(exp_rdata, exp_err, exp_lat);
        send(we, size, sgn, addr, wd);
        expect_rsp(tag);
    endtask

    task automatic txn_m(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input int unsigned addr, input logic [31:0] wd);
        int unsigned nb;
        logic        err;
        int          lat;
        logic [31:0] rd;
        nb  = nbytes(size);
        err = (size == 2'b11);
`ifdef RAM_BOUNDS_CHECK_EN
        if (addr + nb > Depth) err = 1'b1;
`endif
        lat = err ? 1 : ((addr % 4) + nb > 4) ? 3 : 2;
        rd  = (err || we) ? 32'h0 : model_load(addr, size, sgn);
        if (!err && we) model_store(addr, size, wd);
        txn(tag, we, size, sgn, addr, wd, rd, err, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;

        #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // Known contents everywhere so every later load has a defined expectation.
        for (int w = 0; w < int'(Depth / 4); w++) txn_m("fill", 1'b1, 2'b10, 1'b0, w * 4, $urandom);

        // Aligned word store / load.
        model_store(32'h10, 2'b10, 32'hDEADBEEF);
        txn("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        txn("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Sub-word loads with and without sign extension.
        txn("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
        txn("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
        txn("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        txn("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2);

        // Word store crossing a word boundary, then loads of both touched words.
        model_store(32'h16, 2'b10, 32'h11223344);
        txn("st_cross", 1'b1, 2'b10, 1'b0, 32'h16, 32'h11223344, 32'h0, 1'b0, 3);
        txn_m("ld_lo_word", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        txn_m("ld_hi_word", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        txn("ld_cross", 1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 32'h11223344, 1'b0, 3);
        txn_m("ld_half_cross", 1'b0, 2'b01, 1'b1, 32'h17, 32'h0);

        // Response held under back-pressure, then back-to-back accept on the release edge.
        bus.rsp_ready = 1'b0;
        sb_push(32'hDEADBEEF, 1'b0, 2);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        e   = sb_q.pop_front();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        check_eq("hold_lat", 32'(lat), 32'(e.lat));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("hold_rdata", bus.rsp_rdata, e.rdata);
            check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = AddrW'(32'h13);
        bus.req_valid  = 1'b1;
        #1;
        check_eq("b2b_req_ready", 32'(bus.req_ready), 32'd1);
        sb_push(32'h000000DE, 1'b0, 2);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_eq("b2b_rsp_consumed", 32'(bus.rsp_valid), 32'd0);
        expect_rsp("b2b");

        // Reserved size errors without touching RAM; wrap-around at the top of the array.
        txn("rsvd", 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEBABE, 32'h0, 1'b1, 1);
        txn("rsvd_noeffect", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        txn_m("wrap_ld", 1'b0, 2'b10, 1'b0, Depth - 2, 32'h0);
        txn_m("wrap_st", 1'b1, 2'b01, 1'b0, Depth - 1, 32'hA55A);
        txn_m("wrap_ld_lo", 1'b0, 2'b10, 1'b0, 0, 32'h0);
        txn_m("wrap_ld_hi", 1'b0, 2'b10, 1'b0, Depth - 4, 32'h0);

        // Asynchronous reset drops a held response immediately.
        bus.rsp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("arst_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during the second beat of a crossing store keeps only the low part.
        send(1'b1, 2'b10, 1'b0, 32'h32, 32'hA1B2C3D4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("acc2_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("acc2_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_m[10'h32] = 8'hD4;
        mem_m[10'h33] = 8'hC3;
        #1;
        check_eq("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        txn_m("rst_lo_part", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        txn_m("rst_hi_part", 1'b0, 2'b10, 1'b0, 32'h34, 32'h0);

        // Mixed random traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            txn_m("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, Depth - 1), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
